// File: rtl/div_f_ctrl_pkg.sv
// Shared binary32 divider constants, FSM/class encodings and operand classifier.
// Pure declarations: no latency, no flow control.
package div_f_ctrl_pkg;

   localparam int EXP_W_P     = 8;
   localparam int MAN_W_P     = 23;
   localparam int WIDTH_P     = 24;
   localparam int RES_WIDTH_P = 27;
   localparam int BIAS        = 127;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   localparam logic [31:0] INF  = 32'h7F80_0000;

   // Flag vector layout is {NV, DZ, OF, UF, NX}
   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_ITER = 3'd2,
      ST_PACK = 3'd3,
      ST_OUT  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_NORM,
      CLS_INF,
      CLS_NAN
   } cls_t;

   // Subnormals fold into zero (denormals-are-zero).
   function automatic cls_t classify(input logic [EXP_W_P-1:0] e, input logic [MAN_W_P-1:0] f);
      if (e == '0)
         return CLS_ZERO;
      else if (e == '1)
         return (f != '0) ? CLS_NAN : CLS_INF;
      else
         return CLS_NORM;
   endfunction

endpackage

// File: rtl/div_f_round.sv
// Normalize, round-to-nearest-even and pack a core quotient into binary32 with {OF,UF,NX}.
// Purely combinational; no flow control.
module div_f_round
   import div_f_ctrl_pkg::*;
#(
   parameter int EXP_W     = 8,
   parameter int MAN_W     = 23,
   parameter int RES_WIDTH = 27
) (
   input  logic [RES_WIDTH-1:0]   q,
   input  logic signed [EXP_W+1:0] e,
   input  logic                   sign,
   output logic [EXP_W+MAN_W:0]   res,
   output logic [2:0]             flags
);

   localparam int E_W = EXP_W + 2;
   localparam int G   = RES_WIDTH - MAN_W - 2;
   localparam logic signed [E_W-1:0] ONE_S  = E_W'(1);
   localparam logic signed [E_W-1:0] ZERO_S = '0;
   localparam logic signed [E_W-1:0] EMAX_S = E_W'((1 << EXP_W) - 1);

   logic [MAN_W:0]         m;
   logic                   g;
   logic                   s;
   logic                   rnd;
   logic [MAN_W+1:0]       m_inc;
   logic [MAN_W-1:0]       frac;
   logic signed [E_W-1:0]  e_n;
   logic signed [E_W-1:0]  e_fin;
   logic                   unused_hidden;

   assign unused_hidden = m_inc[MAN_W];

   always_comb begin
      // Quotient lies in (0.5, 2): a clear integer bit costs one exponent step.
      if (q[RES_WIDTH-1]) begin
         m   = q[RES_WIDTH-1 -: MAN_W+1];
         g   = q[G];
         s   = |q[G-1:0];
         e_n = e;
      end else begin
         m   = q[RES_WIDTH-2 -: MAN_W+1];
         g   = q[G-1];
         s   = |q[G-2:0];
         e_n = e - ONE_S;
      end
      rnd   = g & (s | m[0]);
      m_inc = {1'b0, m} + {{(MAN_W+1){1'b0}}, rnd};
      frac  = m_inc[MAN_W+1] ? '0 : m_inc[MAN_W-1:0];
      e_fin = m_inc[MAN_W+1] ? (e_n + ONE_S) : e_n;

      flags = '0;
      if (e_fin >= EMAX_S) begin
         res            = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags[FLAG_OF] = 1'b1;
         flags[FLAG_NX] = 1'b1;
      end else if (e_fin <= ZERO_S) begin
         res            = {sign, {(EXP_W+MAN_W){1'b0}}};
         flags[FLAG_UF] = 1'b1;
         flags[FLAG_NX] = 1'b1;
      end else begin
         res            = {sign, e_fin[EXP_W-1:0], frac};
         flags[FLAG_NX] = g | s;
      end
   end

endmodule

// File: rtl/div_f_ctrl.sv
// binary32 divide sequencer around div_f_core: specials in 1 cycle, else LOAD/ITER(<=27)/PACK then OUT.
// One op in flight; in_ready low until the result handshake, result held while out_ready is low.
module div_f_ctrl
   import div_f_ctrl_pkg::*;
#(
   parameter int EXP_W     = EXP_W_P,
   parameter int MAN_W     = MAN_W_P,
   parameter int WIDTH     = WIDTH_P,
   parameter int RES_WIDTH = RES_WIDTH_P
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   in_a,
   input  logic [EXP_W+MAN_W:0]   in_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_data,
   output logic [4:0]             out_flags,
   output logic [2*WIDTH-1:0]     core_init_val,
   output logic                   core_ld,
   output logic                   core_sl,
   input  logic                   core_done,
   input  logic [RES_WIDTH-1:0]   core_res
);

   localparam int DW  = 1 + EXP_W + MAN_W;
   localparam int E_W = EXP_W + 2;
   localparam logic signed [E_W-1:0] BIAS_S = E_W'(BIAS);

   state_t                state;
   logic                  sign_r;
   logic [EXP_W-1:0]      exp_a;
   logic [EXP_W-1:0]      exp_b;
   logic [WIDTH-1:0]      man_a;
   logic [WIDTH-1:0]      man_b;

   cls_t                  ca;
   cls_t                  cb;
   logic                  in_sign;
   logic                  spec_hit;
   logic [DW-1:0]         spec_res;
   logic [4:0]            spec_flags;
   logic signed [E_W-1:0] e_q;
   logic [DW-1:0]         rnd_res;
   logic [2:0]            rnd_flags;

   // Handshake and core controls decode straight from the state register.
   assign in_ready      = (state == ST_IDLE);
   assign core_ld       = (state == ST_LOAD);
   assign core_sl       = (state == ST_ITER);
   assign out_valid     = (state == ST_OUT);
   assign core_init_val = {man_a, man_b};

   assign e_q = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS_S;

   always_comb begin
      ca         = classify(in_a[DW-2:MAN_W], in_a[MAN_W-1:0]);
      cb         = classify(in_b[DW-2:MAN_W], in_b[MAN_W-1:0]);
      in_sign    = in_a[DW-1] ^ in_b[DW-1];
      spec_hit   = 1'b1;
      spec_res   = '0;
      spec_flags = '0;
      if (ca == CLS_NAN || cb == CLS_NAN) begin
         spec_res = QNAN;
      end else if ((ca == CLS_ZERO && cb == CLS_ZERO) || (ca == CLS_INF && cb == CLS_INF)) begin
         spec_res            = QNAN;
         spec_flags[FLAG_NV] = 1'b1;
      end else if (cb == CLS_ZERO) begin
         spec_res            = INF | {in_sign, {(DW-1){1'b0}}};
         spec_flags[FLAG_DZ] = 1'b1;
      end else if (ca == CLS_INF) begin
         spec_res = INF | {in_sign, {(DW-1){1'b0}}};
      end else if (ca == CLS_ZERO || cb == CLS_INF) begin
         spec_res = {in_sign, {(DW-1){1'b0}}};
      end else begin
         spec_hit = 1'b0;
      end
   end

   div_f_round #(
      .EXP_W     (EXP_W),
      .MAN_W     (MAN_W),
      .RES_WIDTH (RES_WIDTH)
   ) u_round (
      .q     (core_res),
      .e     (e_q),
      .sign  (sign_r),
      .res   (rnd_res),
      .flags (rnd_flags)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         sign_r    <= 1'b0;
         exp_a     <= '0;
         exp_b     <= '0;
         man_a     <= '0;
         man_b     <= '0;
         out_data  <= '0;
         out_flags <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  sign_r <= in_sign;
                  exp_a  <= in_a[DW-2:MAN_W];
                  exp_b  <= in_b[DW-2:MAN_W];
                  man_a  <= {1'b1, in_a[MAN_W-1:0]};
                  man_b  <= {1'b1, in_b[MAN_W-1:0]};
                  if (spec_hit) begin
                     out_data  <= spec_res;
                     out_flags <= spec_flags;
                     state     <= ST_OUT;
                  end else begin
                     state <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: state <= ST_ITER;
            // done marks the current shift as the last one
            ST_ITER: if (core_done) state <= ST_PACK;
            ST_PACK: begin
               out_data  <= rnd_res;
               out_flags <= {2'b00, rnd_flags};
               state     <= ST_OUT;
            end
            ST_OUT: if (out_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_f_ctrl.sv
// Directed bench for div_f_ctrl with a behavioural restoring-division core model.
module tb_div_f_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic [4:0]  out_flags;
   logic [47:0] core_init_val;
   logic        core_ld;
   logic        core_sl;
   logic        core_done;
   logic [26:0] core_res;

   int n_chk = 0;
   int n_fail = 0;
   int ld_cnt = 0;
   int sl_cnt = 0;

   always #5 clk = ~clk;

   div_f_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_a          (in_a),
      .in_b          (in_b),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_flags     (out_flags),
      .core_init_val (core_init_val),
      .core_ld       (core_ld),
      .core_sl       (core_sl),
      .core_done     (core_done),
      .core_res      (core_res)
   );

   // Core model: one quotient bit per shift, done on the 27th shift or an exact
   // remainder; a nonzero final remainder is jammed into the LSB as sticky.
   logic [24:0] rem;
   logic [26:0] q_m;
   logic [4:0]  cnt;
   logic [23:0] bm;
   logic        qbit;

   always_comb begin
      bm        = core_init_val[23:0];
      qbit      = (rem >= {1'b0, bm});
      core_done = (cnt == 5'd26) || (qbit && rem == {1'b0, bm});
      core_res  = (q_m << (5'd27 - cnt)) | {26'd0, (rem != 25'd0)};
   end

   always @(posedge clk) begin
      if (core_ld) begin
         rem <= {1'b0, core_init_val[47:24]};
         q_m <= '0;
         cnt <= '0;
      end else if (core_sl) begin
         rem <= qbit ? ((rem - {1'b0, bm}) << 1) : (rem << 1);
         q_m <= {q_m[25:0], qbit};
         cnt <= cnt + 5'd1;
      end
      if (core_ld) ld_cnt <= ld_cnt + 1;
      if (core_sl) sl_cnt <= sl_cnt + 1;
   end

   // Drives one operand pair, waits (bounded) for the result and completes the handshake.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] d,
                         output logic [4:0] f, output int lat, output int lds, output int sls);
      int ld0;
      int sl0;
      @(negedge clk);
      in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
      ld0 = ld_cnt; sl0 = sl_cnt;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      d = out_data; f = out_flags;
      lds = ld_cnt - ld0; sls = sl_cnt - sl0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #2;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_chk++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      n_chk++; if (out_flags !== 5'h0) begin n_fail++; $display("FAIL reset_out_flags got=%b exp=0", out_flags); end
      n_chk++; if (core_init_val !== 48'h0) begin n_fail++; $display("FAIL reset_init_val got=%h exp=0", core_init_val); end
      n_chk++; if (core_ld !== 1'b0 || core_sl !== 1'b0) begin n_fail++; $display("FAIL reset_core_ctl got=%b%b exp=00", core_ld, core_sl); end
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_div_exact();
      logic [31:0] d; logic [4:0] f; int lat, lds, sls;
      run_op(32'h40C00000, 32'h40000000, d, f, lat, lds, sls);
      n_chk++; if (d !== 32'h40400000) begin n_fail++; $display("FAIL exact_data got=%h exp=40400000", d); end
      n_chk++; if (f !== 5'b00000) begin n_fail++; $display("FAIL exact_flags got=%b exp=00000", f); end
      n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL exact_latency got=%0d exp=5", lat); end
      n_chk++; if (lds !== 1) begin n_fail++; $display("FAIL exact_ld_pulses got=%0d exp=1", lds); end
      n_chk++; if (sls !== 2) begin n_fail++; $display("FAIL exact_shifts got=%0d exp=2", sls); end
   endtask

   task automatic test_div_inexact();
      logic [31:0] d; logic [4:0] f; int lat, lds, sls;
      run_op(32'h3F800000, 32'h40400000, d, f, lat, lds, sls);
      n_chk++; if (d !== 32'h3EAAAAAB) begin n_fail++; $display("FAIL third_data got=%h exp=3eaaaaab", d); end
      n_chk++; if (f !== 5'b00001) begin n_fail++; $display("FAIL third_flags got=%b exp=00001", f); end
      n_chk++; if (lat !== 30) begin n_fail++; $display("FAIL third_latency got=%0d exp=30", lat); end
      n_chk++; if (lds !== 1) begin n_fail++; $display("FAIL third_ld_pulses got=%0d exp=1", lds); end
      n_chk++; if (sls !== 27) begin n_fail++; $display("FAIL third_shifts got=%0d exp=27", sls); end
   endtask

   task automatic test_specials();
      logic [31:0] sa [8];
      logic [31:0] sb [8];
      logic [31:0] sr [8];
      logic [4:0]  sf [8];
      logic [31:0] d; logic [4:0] f; int lat, lds, sls;
      sa[0] = 32'h3F800000; sb[0] = 32'h00000000; sr[0] = 32'h7F800000; sf[0] = 5'b01000;
      sa[1] = 32'h00000000; sb[1] = 32'h00000000; sr[1] = 32'h7FC00000; sf[1] = 5'b10000;
      sa[2] = 32'h7FC00001; sb[2] = 32'h3F800000; sr[2] = 32'h7FC00000; sf[2] = 5'b00000;
      sa[3] = 32'h7F800000; sb[3] = 32'hFF800000; sr[3] = 32'h7FC00000; sf[3] = 5'b10000;
      sa[4] = 32'hFF800000; sb[4] = 32'h40000000; sr[4] = 32'hFF800000; sf[4] = 5'b00000;
      sa[5] = 32'h3F800000; sb[5] = 32'h7F800000; sr[5] = 32'h00000000; sf[5] = 5'b00000;
      sa[6] = 32'h00000001; sb[6] = 32'hBF800000; sr[6] = 32'h80000000; sf[6] = 5'b00000;
      sa[7] = 32'hBF800000; sb[7] = 32'h00000000; sr[7] = 32'hFF800000; sf[7] = 5'b01000;
      for (int i = 0; i < 8; i++) begin
         run_op(sa[i], sb[i], d, f, lat, lds, sls);
         n_chk++; if (d !== sr[i]) begin n_fail++; $display("FAIL special%0d_data got=%h exp=%h", i, d, sr[i]); end
         n_chk++; if (f !== sf[i]) begin n_fail++; $display("FAIL special%0d_flags got=%b exp=%b", i, f, sf[i]); end
         n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL special%0d_latency got=%0d exp=1", i, lat); end
         n_chk++; if (lds !== 0) begin n_fail++; $display("FAIL special%0d_ld_pulses got=%0d exp=0", i, lds); end
      end
   endtask

   task automatic test_range();
      logic [31:0] d; logic [4:0] f; int lat, lds, sls;
      run_op(32'h7F7FFFFF, 32'h3F000000, d, f, lat, lds, sls);
      n_chk++; if (d !== 32'h7F800000) begin n_fail++; $display("FAIL overflow_data got=%h exp=7f800000", d); end
      n_chk++; if (f !== 5'b00101) begin n_fail++; $display("FAIL overflow_flags got=%b exp=00101", f); end
      run_op(32'h00800000, 32'h40000000, d, f, lat, lds, sls);
      n_chk++; if (d !== 32'h00000000) begin n_fail++; $display("FAIL underflow_data got=%h exp=00000000", d); end
      n_chk++; if (f !== 5'b00011) begin n_fail++; $display("FAIL underflow_flags got=%b exp=00011", f); end
   endtask

   task automatic test_backpressure();
      logic [31:0] d; logic [4:0] f; int lat, lds, sls;
      int n;
      @(negedge clk);
      out_ready = 1'b0;
      in_a = 32'h40C00000; in_b = 32'h40000000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
      n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_result_timeout got=%b exp=1", out_valid); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_a = 32'h3F800000; in_b = 32'h00000000; in_valid = 1'b1;
         @(posedge clk); #1;
         n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid%0d got=%b exp=1", i, out_valid); end
         n_chk++; if (out_data !== 32'h40400000) begin n_fail++; $display("FAIL bp_hold_data%0d got=%h exp=40400000", i, out_data); end
         n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d got=%b exp=0", i, in_ready); end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
      repeat (2) @(posedge clk); #1;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_not_queued got=%b exp=0", out_valid); end
      run_op(32'h3F800000, 32'h00000000, d, f, lat, lds, sls);
      n_chk++; if (d !== 32'h7F800000 || f !== 5'b01000) begin n_fail++; $display("FAIL bp_next_op got=%h/%b exp=7f800000/01000", d, f); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic [4:0] f; int lat, lds, sls;
      @(negedge clk);
      in_a = 32'h3F800000; in_b = 32'h40400000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk); #1;
      n_chk++; if (core_sl !== 1'b1) begin n_fail++; $display("FAIL midrst_in_iter got=%b exp=1", core_sl); end
      rst = 1'b0;
      #1;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
      n_chk++; if (core_sl !== 1'b0) begin n_fail++; $display("FAIL midrst_core_sl got=%b exp=0", core_sl); end
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run_op(32'h40C00000, 32'h40000000, d, f, lat, lds, sls);
      n_chk++; if (d !== 32'h40400000) begin n_fail++; $display("FAIL midrst_rerun_data got=%h exp=40400000", d); end
      n_chk++; if (f !== 5'b00000) begin n_fail++; $display("FAIL midrst_rerun_flags got=%b exp=00000", f); end
      n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL midrst_rerun_latency got=%0d exp=5", lat); end
   endtask

   initial begin
      test_reset();
      test_div_exact();
      test_div_inexact();
      test_specials();
      test_range();
      test_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
